// File: rtl/cl_scrb_wr_ctl.sv
// Memory scrub write controller: sweeps 0..MAX_ADDR with zero-filled AXI write
// bursts, one burst outstanding at a time, and flags any non-OKAY response.
//
// state | meaning
// IDLE  | waiting for scrb_enable; scrub pointer restarts at 0 on start
// ADDR  | AW issued for burst at scrb_addr, waiting for awready
// DATA  | streaming BURST_LEN zero beats, wlast on the final one
// RESP  | waiting for the B response of the current burst
// DONE  | whole range scrubbed; held until scrb_enable drops
module cl_scrb_wr_ctl #(
  parameter logic [63:0] MAX_ADDR  = 64'h3_FFFF_FFFF,
  parameter int          BURST_LEN = 64,
  parameter logic [15:0] AXI_ID    = 16'h0
) (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic         scrb_enable,
  output logic [63:0]  scrb_addr,
  output logic [2:0]   scrb_state,
  output logic         scrb_done,
  output logic         scrb_err,
  output logic [15:0]  awid,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [15:0]  wid,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [15:0]  bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [63:0] BURST_BYTES = 64'(BURST_LEN * 64);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);

  logic [2:0]  state;
  logic [7:0]  beat_cnt;
  logic [63:0] next_addr;
  logic        unused_bid;

  // Response ID is not checked: only one burst is ever in flight.
  assign unused_bid = ^bid;
  assign next_addr  = scrb_addr + BURST_BYTES;

  assign scrb_state = state;
  assign awid       = AXI_ID;
  assign awaddr     = scrb_addr;
  assign awlen      = LAST_BEAT;
  assign awsize     = 3'd6;
  assign awvalid    = (state == S_ADDR);
  assign wid        = AXI_ID;
  assign wdata      = '0;
  assign wstrb      = '1;
  assign wvalid     = (state == S_DATA);
  assign wlast      = (state == S_DATA) && (beat_cnt == LAST_BEAT);
  assign bready     = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state     <= S_IDLE;
      scrb_addr <= '0;
      scrb_done <= 1'b0;
      scrb_err  <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (scrb_enable) begin
            state     <= S_ADDR;
            scrb_addr <= '0;
            scrb_err  <= 1'b0;
            scrb_done <= 1'b0;
          end
        end
        S_ADDR: begin
          if (awready) state <= S_DATA;
        end
        S_DATA: begin
          if (wready) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= S_RESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        S_RESP: begin
          // Enable is only consulted here, so a dropped enable never cuts a burst short.
          if (bvalid) begin
            scrb_err  <= scrb_err | (bresp != 2'b00);
            scrb_addr <= next_addr;
            if (next_addr > MAX_ADDR) begin
              state     <= S_DONE;
              scrb_done <= 1'b1;
            end else if (scrb_enable) begin
              state <= S_ADDR;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (!scrb_enable) begin
            state     <= S_IDLE;
            scrb_done <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_scrb_wr_ctl.sv
// Bench for cl_scrb_wr_ctl: table of scrub scenarios against a 4-burst
// configuration, plus reset-mid-burst and single-beat-burst sequences.
module tb_cl_scrb_wr_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sync_rst;

  logic         en0, awready0, wready0, bvalid0;
  logic [1:0]   bresp0;
  logic [15:0]  bid0;
  logic [63:0]  scrb_addr0, awaddr0, wstrb0;
  logic [2:0]   scrb_state0, awsize0;
  logic         scrb_done0, scrb_err0, awvalid0, wlast0, wvalid0, bready0;
  logic [15:0]  awid0, wid0;
  logic [7:0]   awlen0;
  logic [511:0] wdata0;

  logic         en1, awready1, wready1, bvalid1;
  logic [1:0]   bresp1;
  logic [15:0]  bid1;
  logic [63:0]  scrb_addr1, awaddr1, wstrb1;
  logic [2:0]   scrb_state1, awsize1;
  logic         scrb_done1, scrb_err1, awvalid1, wlast1, wvalid1, bready1;
  logic [15:0]  awid1, wid1;
  logic [7:0]   awlen1;
  logic [511:0] wdata1;

  cl_scrb_wr_ctl #(.MAX_ADDR(64'h3FFF), .BURST_LEN(64), .AXI_ID(16'h0)) dut0 (
    .clk(clk), .sync_rst(sync_rst), .scrb_enable(en0),
    .scrb_addr(scrb_addr0), .scrb_state(scrb_state0), .scrb_done(scrb_done0), .scrb_err(scrb_err0),
    .awid(awid0), .awaddr(awaddr0), .awlen(awlen0), .awsize(awsize0), .awvalid(awvalid0), .awready(awready0),
    .wid(wid0), .wdata(wdata0), .wstrb(wstrb0), .wlast(wlast0), .wvalid(wvalid0), .wready(wready0),
    .bid(bid0), .bresp(bresp0), .bvalid(bvalid0), .bready(bready0)
  );

  cl_scrb_wr_ctl #(.MAX_ADDR(64'hFF), .BURST_LEN(1), .AXI_ID(16'h0)) dut1 (
    .clk(clk), .sync_rst(sync_rst), .scrb_enable(en1),
    .scrb_addr(scrb_addr1), .scrb_state(scrb_state1), .scrb_done(scrb_done1), .scrb_err(scrb_err1),
    .awid(awid1), .awaddr(awaddr1), .awlen(awlen1), .awsize(awsize1), .awvalid(awvalid1), .awready(awready1),
    .wid(wid1), .wdata(wdata1), .wstrb(wstrb1), .wlast(wlast1), .wvalid(wvalid1), .wready(wready1),
    .bid(bid1), .bresp(bresp1), .bvalid(bvalid1), .bready(bready1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Burst numbers in the table are 1-based; drop_beat is the 0-based beat index.
  typedef struct {
    bit          stall;
    int          err_burst;
    int          drop_burst;
    int          drop_beat;
    int          exp_bursts;
    bit          exp_done;
    logic [63:0] exp_addr;
    logic [2:0]  exp_state;
    bit          exp_err;
  } scen_t;

  scen_t scen[6];

  // Drives an AXI slave for dut0 and checks every cycle against a burst model.
  task automatic run0(input scen_t s, output int bursts, output int bad_aw, output int bad_w,
                      output int bad_beats, output int bad_proto, output bit timeout,
                      output logic first_err, output logic first_done);
    logic [63:0] exp_addr;
    int  beat;
    bit  started, aw_pend, w_pend;
    exp_addr = 64'h0; beat = 0; started = 0; aw_pend = 0; w_pend = 0;
    bursts = 0; bad_aw = 0; bad_w = 0; bad_beats = 0; bad_proto = 0; timeout = 1;
    first_err = 1'bx; first_done = 1'bx;
    en0 = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (awvalid0 && wvalid0) bad_proto++;
      if (aw_pend && !awvalid0) bad_proto++;
      if (w_pend && !wvalid0) bad_proto++;
      if (awvalid0) begin
        if (!started) begin
          first_err  = scrb_err0;
          first_done = scrb_done0;
        end
        started = 1;
        if (awaddr0 !== exp_addr || awlen0 !== 8'd63 || awsize0 !== 3'd6 || awid0 !== 16'h0) bad_aw++;
      end
      if (wvalid0) begin
        if (wlast0 !== (beat == 63) || wdata0 !== '0 || wstrb0 !== '1 || wid0 !== 16'h0) bad_w++;
        if (bursts + 1 == s.drop_burst && beat == s.drop_beat) en0 = 1'b0;
      end else if (wlast0 !== 1'b0) begin
        bad_w++;
      end
      if (bready0 && beat != 64) bad_beats++;
      if (started && (scrb_state0 == 3'd4 || scrb_state0 == 3'd0)) begin
        timeout = 0;
        break;
      end
      awready0 = s.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready0  = s.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid0  = bready0 && (s.stall ? 1'($urandom_range(0, 1)) : 1'b1);
      bresp0   = (bursts + 1 == s.err_burst) ? 2'b10 : 2'b00;
      bid0     = 16'h5a5a;
      aw_pend  = awvalid0 && !awready0;
      w_pend   = wvalid0 && !wready0;
      if (awvalid0 && awready0) beat = 0;
      if (wvalid0 && wready0) beat++;
      if (bready0 && bvalid0) begin
        exp_addr += 64'h1000;
        bursts++;
        beat = 0;
      end
    end
    awready0 = 1'b0; wready0 = 1'b0; bvalid0 = 1'b0; bresp0 = 2'b00;
  endtask

  initial begin
    int bursts, bad_aw, bad_w, bad_beats, bad_proto;
    bit timeout;
    logic first_err, first_done;
    int n1, bad1;
    bit to1;

    scen[0] = '{0, 0, 0, 0, 4, 1, 64'h4000, 3'd4, 0};
    scen[1] = '{1, 0, 0, 0, 4, 1, 64'h4000, 3'd4, 0};
    scen[2] = '{0, 1, 0, 0, 4, 1, 64'h4000, 3'd4, 1};
    scen[3] = '{1, 3, 0, 0, 4, 1, 64'h4000, 3'd4, 1};
    scen[4] = '{0, 0, 2, 9, 2, 0, 64'h2000, 3'd0, 0};
    scen[5] = '{1, 0, 2, 9, 2, 0, 64'h2000, 3'd0, 0};

    sync_rst = 1'b1;
    en0 = 1'b0; awready0 = 1'b0; wready0 = 1'b0; bvalid0 = 1'b0; bresp0 = 2'b00; bid0 = 16'h0;
    en1 = 1'b0; awready1 = 1'b1; wready1 = 1'b1; bvalid1 = 1'b1; bresp1 = 2'b00; bid1 = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_state", scrb_state0, 0);
    chk("rst_addr", scrb_addr0, 0);
    chk("rst_done", scrb_done0, 0);
    chk("rst_err", scrb_err0, 0);
    chk("rst_valids", {awvalid0, wvalid0, wlast0, bready0}, 0);
    chk("rst_awlen", awlen0, 63);
    chk("rst_awsize", awsize0, 6);
    chk("rst_wstrb", wstrb0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_wdata_zero", (wdata0 == '0), 1);
    chk("rst_ids", {awid0, wid0}, 0);
    sync_rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", scrb_state0, 0);

    for (int i = 0; i < 6; i++) begin
      run0(scen[i], bursts, bad_aw, bad_w, bad_beats, bad_proto, timeout, first_err, first_done);
      chk($sformatf("s%0d_timeout", i), timeout, 0);
      chk($sformatf("s%0d_bursts", i), bursts, scen[i].exp_bursts);
      chk($sformatf("s%0d_aw_payload", i), bad_aw, 0);
      chk($sformatf("s%0d_w_beats", i), bad_w, 0);
      chk($sformatf("s%0d_beat_count", i), bad_beats, 0);
      chk($sformatf("s%0d_handshake_rules", i), bad_proto, 0);
      chk($sformatf("s%0d_start_err_clear", i), first_err, 0);
      chk($sformatf("s%0d_start_done_clear", i), first_done, 0);
      chk($sformatf("s%0d_state", i), scrb_state0, scen[i].exp_state);
      chk($sformatf("s%0d_done", i), scrb_done0, scen[i].exp_done);
      chk($sformatf("s%0d_addr", i), scrb_addr0, scen[i].exp_addr);
      chk($sformatf("s%0d_err", i), scrb_err0, scen[i].exp_err);
      if (scen[i].exp_done) begin
        @(negedge clk);
        chk($sformatf("s%0d_done_held", i), {scrb_state0, scrb_done0}, {3'd4, 1'b1});
      end
      en0 = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("s%0d_back_idle", i), {scrb_state0, scrb_done0}, {3'd0, 1'b0});
    end

    // Reset asserted while beat 5 of the first burst is being presented.
    en0 = 1'b1; awready0 = 1'b1; wready0 = 1'b1;
    for (int c = 0; c < 50 && !wvalid0; c++) @(negedge clk);
    chk("mid_rst_reached_data", wvalid0, 1);
    repeat (5) @(negedge clk);
    chk("mid_rst_in_data", scrb_state0, 2);
    sync_rst = 1'b1; en0 = 1'b0; awready0 = 1'b0; wready0 = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", scrb_state0, 0);
    chk("mid_rst_addr", scrb_addr0, 0);
    chk("mid_rst_flags", {scrb_done0, scrb_err0, awvalid0, wvalid0, wlast0, bready0}, 0);
    chk("mid_rst_consts", {awlen0, awsize0, wstrb0}, {8'd63, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF});
    sync_rst = 1'b0;
    @(negedge clk);
    run0(scen[0], bursts, bad_aw, bad_w, bad_beats, bad_proto, timeout, first_err, first_done);
    chk("post_rst_timeout", timeout, 0);
    chk("post_rst_bursts", bursts, 4);
    chk("post_rst_aw_payload", bad_aw, 0);
    chk("post_rst_w_beats", bad_w, 0);
    chk("post_rst_done_addr", {scrb_done0, scrb_addr0}, {1'b1, 64'h4000});
    en0 = 1'b0;
    repeat (2) @(negedge clk);

    // Single-beat bursts on the second instance, slave always ready.
    n1 = 0; bad1 = 0; to1 = 1;
    en1 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (awvalid1) begin
        if (awaddr1 !== 64'(n1) * 64'h40 || awlen1 !== 8'd0) bad1++;
      end
      if (wvalid1) begin
        if (wlast1 !== 1'b1) bad1++;
        n1++;
      end
      if (scrb_state1 == 3'd4) begin
        to1 = 0;
        break;
      end
    end
    chk("b1_timeout", to1, 0);
    chk("b1_beats", n1, 4);
    chk("b1_aw_wlast", bad1, 0);
    chk("b1_done", scrb_done1, 1);
    chk("b1_addr", scrb_addr1, 64'h100);
    en1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("b1_idle", {scrb_state1, scrb_done1}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cl_scrb_wr_ctl.md
CL_SCRB_WR_CTL -- requirements
Module: cl_scrb_wr_ctl

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 64'h3_FFFF_FFFF, last byte address to scrub; (MAX_ADDR+1) is a multiple of BURST_LEN*64.
REQ-002 SHALL have parameter BURST_LEN, default 64, beats per burst; power of two, 1..64, so BURST_LEN*64 <= 4096 bytes.
REQ-003 SHALL have parameter AXI_ID, default 16'h0, value driven on awid/wid.
REQ-004 SHALL have ports:
- clk  in  1  sole clock.
- sync_rst  in  1  synchronous, active-high reset.
- scrb_enable  in  1  scrub request, level.
- scrb_addr  out  64  address of the current/next burst.
- scrb_state  out  3  FSM state encoding.
- scrb_done  out  1  scrub complete.
- scrb_err  out  1  sticky, any non-OKAY bresp seen this pass.
- awid/awaddr/awlen/awsize/awvalid  out  16/64/8/3/1  AXI write address.
- awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  16/512/64/1/1  AXI write data.
- wready  in  1.
- bid/bresp/bvalid  in  16/2/1  AXI write response.
- bready  out  1.

Function
REQ-005 SHALL implement states IDLE=0, ADDR=1, DATA=2, RESP=3, DONE=4, driven on scrb_state.
REQ-006 IDLE: scrb_enable=1 -> ADDR next cycle; scrb_addr<=0, scrb_err<=0, scrb_done<=0.
REQ-007 ADDR: awvalid=1, awaddr=scrb_addr, awlen=BURST_LEN-1, awsize=3'd6, awid=AXI_ID; held stable until awready; on awvalid&awready -> DATA.
REQ-008 DATA: wvalid=1, wdata=0, wstrb=all ones, wid=AXI_ID; 8-bit beat counter increments on wvalid&wready; wlast=1 only when counter=BURST_LEN-1; last beat accepted -> RESP, counter cleared.
REQ-009 RESP: bready=1; on bvalid, scrb_err<=scrb_err|(bresp!=0); bid not checked.
REQ-010 On RESP completion, scrb_addr<=scrb_addr+BURST_LEN*64 (64-bit wrap-free since MAX_ADDR < 2^64-4096).
REQ-011 On RESP completion: new address > MAX_ADDR -> DONE; else scrb_enable=1 -> ADDR; else -> IDLE.
REQ-012 DONE: scrb_done=1, scrb_addr holds MAX_ADDR+1; stays while scrb_enable=1; scrb_enable=0 -> IDLE with scrb_done cleared.
REQ-013 scrb_enable deassert in ADDR/DATA/RESP SHALL NOT abort: current burst completes (AW, all beats, B), then IDLE per REQ-011; scrb_done stays 0.
REQ-014 Exactly one burst outstanding; awvalid and wvalid never asserted in the same cycle.
REQ-015 awvalid/wvalid SHALL NOT deassert before handshake; payload constant while valid.
REQ-016 Single-beat case (BURST_LEN=1): wlast=1 on the only beat.
REQ-017 No read channel; block never issues AR.

Reset
REQ-018 sync_rst=1 at a clk edge SHALL force IDLE, regardless of state, including mid-burst.
REQ-019 Reset values: scrb_addr=0, scrb_state=0, scrb_done=0, scrb_err=0, awvalid=0, wvalid=0, wlast=0, bready=0, beat counter=0.
REQ-020 awid/wid=AXI_ID, awlen=BURST_LEN-1, awsize=6, wdata=0, wstrb=all ones constantly, including during reset.

Verification
REQ-021 MAX_ADDR=0x3FFF, BURST_LEN=64, always-ready slave, enable held -> 4 bursts at 0x0,0x1000,0x2000,0x3000, 64 beats each, wlast on beat 63; scrb_done=1, scrb_addr=0x4000, state=4.
REQ-022 Slave with random awready/wready/bvalid stalls -> AW/W payload stable under stall, no beat lost; identical 4-burst sequence; scrb_err=0.
REQ-023 Enable dropped during beat 10 of burst 2 -> burst 2 completes all 64 beats and B; IDLE, scrb_done=0; re-enable restarts at awaddr=0.
REQ-024 bresp=2'b10 on burst 1 only -> scrb_err=1 through DONE; cleared on next IDLE->ADDR start.
REQ-025 sync_rst pulsed in DATA at beat 5 -> next cycle all outputs at reset values; re-enable issues awaddr=0.
REQ-026 BURST_LEN=1, MAX_ADDR=0xFF -> 4 single-beat bursts at 0x0,0x40,0x80,0xC0, wlast=1 each; scrb_done=1.
